// File: rtl/instruction_mem_fetch_pkg.sv
// Shared definitions for the loadable instruction memory / fetch block:
// opcode encodings, FSM states and default widths.
package instruction_mem_fetch_pkg;

  localparam int DEF_ADDR_W  = 10;
  localparam int DEF_INSTR_W = 16;

  // 6-bit opcode field on top of a 10-bit operand
  localparam logic [5:0] OP_LDA  = 6'h01;
  localparam logic [5:0] OP_ADDA = 6'h02;
  localparam logic [5:0] OP_STA  = 6'h03;
  localparam logic [5:0] OP_JMP  = 6'h04;
  localparam logic [5:0] OP_NOP  = 6'h3F;

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_IDLE  = 2'd1,
    ST_RUN   = 2'd2
  } fetch_state_t;

  function automatic logic [15:0] make_instr(input logic [5:0] op, input logic [9:0] operand);
    return {op, operand};
  endfunction

endpackage

// File: rtl/instruction_mem_fetch_if.sv
// Loader and fetch-stream signals between the program loader / IF stage
// (master) and the instruction memory (slave).
interface instruction_mem_fetch_if
  import instruction_mem_fetch_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int INSTR_W = DEF_INSTR_W
);

  logic               load_en;
  logic [ADDR_W-1:0]  load_addr;
  logic [INSTR_W-1:0] load_data;
  logic               start;
  logic               halt;
  logic               stall;
  logic               branch_taken;
  logic [ADDR_W-1:0]  branch_target;
  logic [INSTR_W-1:0] instruction;
  logic [ADDR_W-1:0]  pc;
  logic               valid;
  logic               ready;
  logic               load_err;

  modport master (
    output load_en, load_addr, load_data, start, halt, stall, branch_taken, branch_target,
    input  instruction, pc, valid, ready, load_err
  );

  modport slave (
    input  load_en, load_addr, load_data, start, halt, stall, branch_taken, branch_target,
    output instruction, pc, valid, ready, load_err
  );

endinterface

// File: rtl/instruction_mem_fetch_sync_ram_1r1w.sv
// Simple dual-port RAM: one write port, one read port with a registered,
// enable-gated output so the read data holds while the reader stalls.
module sync_ram_1r1w #(
  parameter int DEPTH = 1024,
  parameter int WIDTH = 16,
  parameter int AW    = 10
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/instruction_mem_fetch.sv
// Loadable instruction memory with a built-in fetch sequencer: optional
// clear sweep after reset, loader writes while idle, streaming fetch with stall and branch.
module instruction_mem_fetch
  import instruction_mem_fetch_pkg::*;
#(
  parameter int                 ADDR_W         = DEF_ADDR_W,
  parameter int                 INSTR_W        = DEF_INSTR_W,
  parameter int                 DEPTH          = 1024,
  parameter int                 RESET_PC       = 0,
  parameter logic [INSTR_W-1:0] FILL_WORD      = INSTR_W'(make_instr(OP_NOP, 10'd0)),
  parameter int                 CLEAR_ON_RESET = 1
) (
  input logic                    clk,
  input logic                    srst,
  instruction_mem_fetch_if.slave bus
);

  localparam int                RAM_AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0]   DEPTH_X   = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] START_PC  = ADDR_W'(RESET_PC);
  localparam fetch_state_t      RST_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;

  fetch_state_t       state_reg, state_next;
  logic [ADDR_W-1:0]  sweep_reg;
  logic [ADDR_W-1:0]  fpc_reg;
  logic [ADDR_W-1:0]  fpc_next;
  logic [ADDR_W-1:0]  pc_reg;
  logic               valid_reg;
  logic               ready_reg;
  logic               load_err_reg;
  logic               fill_sel_reg;

  logic               ram_we;
  logic               ram_re;
  logic [ADDR_W-1:0]  ram_waddr;
  logic [INSTR_W-1:0] ram_wdata;
  logic [INSTR_W-1:0] ram_rdata;
  logic               fetch_fire;
  logic               redirect;
  logic               fpc_in_range;
  logic               load_in_range;

  assign fpc_in_range  = ({1'b0, fpc_reg} < DEPTH_X);
  assign load_in_range = ({1'b0, bus.load_addr} < DEPTH_X);
  // Sequential wrap is at DEPTH, not at 2**ADDR_W
  assign fpc_next      = (fpc_reg == LAST_ADDR) ? '0 : fpc_reg + ADDR_W'(1);

  always_ff @(posedge clk) begin
    if (srst) begin
      state_reg <= RST_STATE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_CLEAR: if (sweep_reg == LAST_ADDR) state_next = ST_IDLE;
      ST_IDLE:  if (bus.start)              state_next = ST_RUN;
      ST_RUN:   if (bus.halt)               state_next = ST_IDLE;
      default:                              state_next = RST_STATE;
    endcase
  end

  always_comb begin
    ram_we     = 1'b0;
    ram_waddr  = bus.load_addr;
    ram_wdata  = bus.load_data;
    ram_re     = 1'b0;
    fetch_fire = 1'b0;
    redirect   = 1'b0;
    case (state_reg)
      ST_CLEAR: begin
        ram_we    = 1'b1;
        ram_waddr = sweep_reg;
        ram_wdata = FILL_WORD;
      end
      ST_IDLE: begin
        ram_we = bus.load_en && load_in_range;
      end
      ST_RUN: begin
        // halt beats branch, branch beats stall
        redirect   = !bus.halt && bus.branch_taken;
        fetch_fire = !bus.halt && !bus.branch_taken && !bus.stall;
        ram_re     = fetch_fire && fpc_in_range;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      sweep_reg    <= '0;
      fpc_reg      <= START_PC;
      pc_reg       <= START_PC;
      valid_reg    <= 1'b0;
      ready_reg    <= 1'b0;
      load_err_reg <= 1'b0;
      fill_sel_reg <= 1'b1;
    end else begin
      ready_reg    <= (state_next == ST_IDLE);
      load_err_reg <= bus.load_en && (state_reg != ST_IDLE);
      if (state_reg == ST_CLEAR) begin
        sweep_reg <= (sweep_reg == LAST_ADDR) ? '0 : sweep_reg + ADDR_W'(1);
      end
      if (state_reg == ST_IDLE && bus.start) begin
        fpc_reg <= START_PC;
      end
      if (redirect) begin
        fpc_reg   <= bus.branch_target;
        valid_reg <= 1'b0;
      end else if (fetch_fire) begin
        fpc_reg      <= fpc_next;
        pc_reg       <= fpc_reg;
        valid_reg    <= 1'b1;
        fill_sel_reg <= !fpc_in_range;
      end else if (state_next != ST_RUN) begin
        valid_reg <= 1'b0;
      end
    end
  end

  sync_ram_1r1w #(
    .DEPTH (DEPTH),
    .WIDTH (INSTR_W),
    .AW    (RAM_AW)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we && !srst),
    .waddr (ram_waddr[RAM_AW-1:0]),
    .wdata (ram_wdata),
    .re    (ram_re),
    .raddr (fpc_reg[RAM_AW-1:0]),
    .rdata (ram_rdata)
  );

  // Out-of-range fetches and the post-reset word never touch the RAM output
  assign bus.instruction = fill_sel_reg ? FILL_WORD : ram_rdata;
  assign bus.pc          = pc_reg;
  assign bus.valid       = valid_reg;
  assign bus.ready       = ready_reg;
  assign bus.load_err    = load_err_reg;

endmodule

// File: tb/tb_instruction_mem_fetch.sv
// Scoreboard bench: a 1024-word instance for clear/load/branch/reset and an
// 8-word instance starting at 6 for wrap, stall and out-of-range handling.
module tb_instruction_mem_fetch;
  import instruction_mem_fetch_pkg::*;

  localparam logic [15:0] FILL = {OP_NOP, 10'd0};

  typedef struct packed {
    logic [9:0]  pc;
    logic [15:0] instr;
  } exp_t;

  logic clk = 1'b0;
  logic srst_b;
  logic srst_s;
  always #5 clk = ~clk;

  instruction_mem_fetch_if #(.ADDR_W(10), .INSTR_W(16)) bb ();
  instruction_mem_fetch_if #(.ADDR_W(10), .INSTR_W(16)) sb ();

  instruction_mem_fetch #(
    .ADDR_W(10), .INSTR_W(16), .DEPTH(1024), .RESET_PC(0), .FILL_WORD(FILL), .CLEAR_ON_RESET(1)
  ) u_big (
    .clk  (clk),
    .srst (srst_b),
    .bus  (bb)
  );

  instruction_mem_fetch #(
    .ADDR_W(10), .INSTR_W(16), .DEPTH(8), .RESET_PC(6), .FILL_WORD(FILL), .CLEAR_ON_RESET(1)
  ) u_small (
    .clk  (clk),
    .srst (srst_s),
    .bus  (sb)
  );

  int          n_checks = 0;
  int          n_errors = 0;
  exp_t        exp_b[$];
  exp_t        exp_s[$];
  exp_t        eb;
  exp_t        es;
  logic [15:0] ref_b [0:1023];
  logic [15:0] ref_s [0:7];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, want);
    end
  endtask

  // Monitors: every valid cycle consumes one scoreboard entry
  always @(negedge clk) begin
    if (bb.valid === 1'b1) begin
      if (exp_b.size() == 0) begin
        check_eq("big_unexpected_valid", 32'(bb.valid), 32'd0);
      end else begin
        eb = exp_b.pop_front();
        $display("txn big   pc=%0d instr=%04h", bb.pc, bb.instruction);
        check_eq("big_pc", 32'(bb.pc), 32'(eb.pc));
        check_eq("big_instr", 32'(bb.instruction), 32'(eb.instr));
      end
    end
  end

  always @(negedge clk) begin
    if (sb.valid === 1'b1) begin
      if (exp_s.size() == 0) begin
        check_eq("small_unexpected_valid", 32'(sb.valid), 32'd0);
      end else begin
        es = exp_s.pop_front();
        $display("txn small pc=%0d instr=%04h", sb.pc, sb.instruction);
        check_eq("small_pc", 32'(sb.pc), 32'(es.pc));
        check_eq("small_instr", 32'(sb.instruction), 32'(es.instr));
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_b(input int pc);
    exp_b.push_back({10'(pc), ref_b[10'(pc)]});
  endtask

  task automatic push_s(input int pc);
    exp_s.push_back({10'(pc), (pc < 8) ? ref_s[3'(pc)] : FILL});
  endtask

  task automatic load_b(input int addr, input logic [15:0] data);
    bb.load_en   = 1'b1;
    bb.load_addr = 10'(addr);
    bb.load_data = data;
    step();
    bb.load_en = 1'b0;
    ref_b[10'(addr)] = data;
  endtask

  task automatic load_s(input int addr, input logic [15:0] data);
    sb.load_en   = 1'b1;
    sb.load_addr = 10'(addr);
    sb.load_data = data;
    step();
    sb.load_en = 1'b0;
    if (addr < 8) ref_s[3'(addr)] = data;
  endtask

  // Start at PC 0, take n sequential fetches, then halt
  task automatic run_b(input int n);
    for (int i = 0; i < n; i++) push_b(i);
    bb.start = 1'b1;
    step();
    bb.start = 1'b0;
    repeat (n) step();
    bb.halt = 1'b1;
    step();
    bb.halt = 1'b0;
    @(negedge clk);
    check_eq("big_valid_after_halt", 32'(bb.valid), 32'd0);
  endtask

  // Called at the negedge of the first cycle after a reset edge
  task automatic measure_clear(output int nb, output int ns);
    bit db;
    bit ds;
    nb = 0;
    ns = 0;
    db = 1'b0;
    ds = 1'b0;
    for (int i = 0; i < 1100 && !(db && ds); i++) begin
      if (!db) begin
        if (bb.ready === 1'b1) db = 1'b1;
        else nb++;
      end
      if (!ds) begin
        if (sb.ready === 1'b1) ds = 1'b1;
        else ns++;
      end
      if (!(db && ds)) @(negedge clk);
    end
  endtask

  int nb;
  int ns;

  initial begin
    for (int i = 0; i < 1024; i++) ref_b[i] = FILL;
    for (int i = 0; i < 8; i++) ref_s[i] = FILL;
    bb.load_en = 1'b0; bb.load_addr = '0; bb.load_data = '0; bb.start = 1'b0; bb.halt = 1'b0;
    bb.stall = 1'b0; bb.branch_taken = 1'b0; bb.branch_target = '0;
    sb.load_en = 1'b0; sb.load_addr = '0; sb.load_data = '0; sb.start = 1'b0; sb.halt = 1'b0;
    sb.stall = 1'b0; sb.branch_taken = 1'b0; sb.branch_target = '0;
    srst_b = 1'b1;
    srst_s = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("big_reset_valid", 32'(bb.valid), 32'd0);
    check_eq("big_reset_pc", 32'(bb.pc), 32'd0);
    check_eq("big_reset_instr", 32'(bb.instruction), 32'(FILL));
    check_eq("big_reset_ready", 32'(bb.ready), 32'd0);
    check_eq("big_reset_load_err", 32'(bb.load_err), 32'd0);
    check_eq("small_reset_pc", 32'(sb.pc), 32'd6);
    check_eq("small_reset_instr", 32'(sb.instruction), 32'(FILL));
    srst_b = 1'b0;
    srst_s = 1'b0;
    measure_clear(nb, ns);
    check_eq("big_clear_cycles", 32'(nb), 32'd1024);
    check_eq("small_clear_cycles", 32'(ns), 32'd8);

    // Freshly cleared memory reads back the fill word
    run_b(8);

    // Loaded program at 0/1, fill beyond
    check_eq("big_ready_idle", 32'(bb.ready), 32'd1);
    load_b(0, make_instr(OP_ADDA, 10'd2));
    load_b(1, make_instr(OP_LDA, 10'd0));
    load_b(30, make_instr(OP_STA, 10'd30));
    load_b(50, make_instr(OP_JMP, 10'd50));
    run_b(4);

    // Small: wrap 7->0, stall at PC 7, branch to out-of-range address 8
    for (int i = 0; i < 8; i++) load_s(i, make_instr(OP_LDA, 10'(i * 7 + 3)));
    load_s(8, 16'hDEAD);
    push_s(6);
    repeat (4) push_s(7);
    push_s(0); push_s(1); push_s(8); push_s(9);
    sb.start = 1'b1;
    step();
    sb.start = 1'b0;
    step();
    step();
    sb.stall = 1'b1;
    repeat (3) step();
    sb.stall = 1'b0;
    step();
    step();
    sb.branch_taken = 1'b1;
    sb.branch_target = 10'd8;
    step();
    sb.branch_taken = 1'b0;
    @(negedge clk);
    check_eq("small_branch_bubble", 32'(sb.valid), 32'd0);
    step();
    step();
    sb.halt = 1'b1;
    step();
    sb.halt = 1'b0;
    @(negedge clk);
    check_eq("small_valid_after_halt", 32'(sb.valid), 32'd0);

    // Big: branch with stall, then back-to-back branches in the bubble
    push_b(0); push_b(1); push_b(30); push_b(31); push_b(50);
    bb.start = 1'b1;
    step();
    bb.start = 1'b0;
    step();
    step();
    bb.branch_taken = 1'b1;
    bb.branch_target = 10'd30;
    bb.stall = 1'b1;
    step();
    bb.branch_taken = 1'b0;
    bb.stall = 1'b0;
    @(negedge clk);
    check_eq("big_branch_stall_bubble", 32'(bb.valid), 32'd0);
    step();
    step();
    bb.branch_taken = 1'b1;
    bb.branch_target = 10'd40;
    step();
    bb.branch_target = 10'd50;
    @(negedge clk);
    check_eq("big_bubble_first", 32'(bb.valid), 32'd0);
    step();
    bb.branch_taken = 1'b0;
    @(negedge clk);
    check_eq("big_bubble_extended", 32'(bb.valid), 32'd0);
    step();
    bb.halt = 1'b1;
    step();
    bb.halt = 1'b0;
    @(negedge clk);
    check_eq("big_valid_after_branch_halt", 32'(bb.valid), 32'd0);

    // Loader write while running is rejected with a one-cycle error pulse
    push_b(0); push_b(1);
    bb.start = 1'b1;
    step();
    bb.start = 1'b0;
    bb.load_en = 1'b1;
    bb.load_addr = 10'd1;
    bb.load_data = 16'hBEEF;
    step();
    bb.load_en = 1'b0;
    @(negedge clk);
    check_eq("big_load_err_pulse", 32'(bb.load_err), 32'd1);
    step();
    @(negedge clk);
    check_eq("big_load_err_clear", 32'(bb.load_err), 32'd0);
    bb.halt = 1'b1;
    step();
    bb.halt = 1'b0;
    run_b(2);

    // Reset in the middle of a run restarts the clear sweep
    push_b(0);
    bb.start = 1'b1;
    step();
    bb.start = 1'b0;
    step();
    srst_b = 1'b1;
    step();
    srst_b = 1'b0;
    @(negedge clk);
    check_eq("big_midrun_reset_valid", 32'(bb.valid), 32'd0);
    check_eq("big_midrun_reset_pc", 32'(bb.pc), 32'd0);
    check_eq("big_midrun_reset_instr", 32'(bb.instruction), 32'(FILL));
    measure_clear(nb, ns);
    check_eq("big_reclear_cycles", 32'(nb), 32'd1024);
    for (int i = 0; i < 1024; i++) ref_b[i] = FILL;
    run_b(2);

    repeat (3) step();
    check_eq("big_scoreboard_left", 32'(exp_b.size()), 32'd0);
    check_eq("small_scoreboard_left", 32'(exp_s.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
